sobel_gradient: RTL and testbench
=================================

# sobel_gradient

- Streaming 3x3 Sobel stage of the edge-detection pipeline.
- Accepts 8-bit grayscale pixels in raster order and buffers two image lines.
- Emits one gradient pair per interior pixel: unsigned 8-bit |gx| and |gy| plus sign bits.
- The magnitude stage consumes gx/gy directly; the direction stage uses the sign bits.

## Interface
- IMG_WIDTH, 640, pixels per line (>= 3)
- IMG_HEIGHT, 480, lines per frame (>= 3)
- clk  in  1  single clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- pix_valid  in  1  pix_in/sof valid this cycle; no backpressure, gaps allowed
- pix_in  in  8  grayscale pixel
- sof  in  1  qualified by pix_valid; marks pixel (0,0) of a frame
- out_valid  out  1  one-cycle pulse per result
- out_sof  out  1  high with the first out_valid of a frame
- gx  out  8  |Sx| >> 2
- gy  out  8  |Sy| >> 2
- gx_neg  out  1  Sx < 0
- gy_neg  out  1  Sy < 0

## Operation
- States:
  - IDLE: after reset, waits for pix_valid&sof.
  - ACTIVE: counting col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1.
  - DONE: after the last pixel of the frame is accepted.
- Transitions:
  - pix_valid&sof in any state → ACTIVE; that pixel becomes (0,0) and the counters restart.
  - Mid-frame sof aborts the current frame; results already emitted stand.
  - Last pixel accepted → DONE.
- pix_valid without sof in IDLE or DONE: ignored; line buffers and window unchanged.
- Line buffers: two IMG_WIDTH x 8 delay lines, advancing only on accepted pixels.
- Window: 3x3 registers w[r][c], with r=0 the oldest row and c=0 the leftmost column.
- Accepted pixel (r,c) with r>=2 and c>=2 completes the window centered at (r-1,c-1) and produces one result. No other pixel produces a result.
- A frame yields exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) results, in raster order. No border outputs.
- Window columns do not wrap across lines: results are suppressed while c<2 on each new row.
- Arithmetic:
  - Sx = (w02+2w12+w22) − (w00+2w10+w20)
  - Sy = (w20+2w21+w22) − (w00+2w01+w02)
  - Both 11-bit signed, range ±1020.
  - gx = |Sx|>>2 and gy = |Sy|>>2; the maximum is exactly 255, so no saturation is needed.
  - gx_neg / gy_neg = sign bit of Sx / Sy; 0 when the value is 0.
- Line-buffer contents are not cleared by reset or sof; the row<2 suppression makes stale data unobservable.

## Timing
- Reset values: out_valid=0, out_sof=0, gx=gy=0, gx_neg=gy_neg=0, state IDLE, counters 0, window 0.
- n_rst low forces all outputs to reset values immediately; a frame in progress is lost, and the next frame requires sof.
- Latency: out_valid is high exactly 2 clk after the pix_valid cycle of the completing pixel.
  - Stage 1: window/line-buffer update.
  - Stage 2: Sobel compute and output register.
- Throughput: one result per cycle when pix_valid is continuous. Output gaps mirror input gaps.
- Outputs hold their last values while out_valid=0.
- sof arriving while a result is in stage 2: that result still emits. The new frame's first result carries out_sof.

## Structure
- Package canny_pkg:
  - PIX_W=8, SOBEL_W=11
  - state_t enum {IDLE, ACTIVE, DONE}
  - pixel_t typedef
  - shared with the magnitude/direction stages
- Sub-module line_buffer (parameter DEPTH=IMG_WIDTH, 8-bit, shift-enable on accept), instantiated twice.
- Top holds the counters, FSM, window and Sobel pipeline.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6.
- Flat frame, all 100, continuous valid → 24 results, all gx=gy=0, neg=0; out_sof only on the first result; first result 2 cycles after pixel (2,2).
- Vertical step, cols 0–3=0, cols 4–7=200 → results at center cols 3 and 4: gx=200, gx_neg=0, gy=0; all others 0.
- Horizontal step, rows 0–2=255, rows 3–5=0 → center rows 2 and 3: gy=255, gy_neg=1, gx=0; rows 1 and 4: 0.
- Scenarios 1–3 repeated with random pix_valid gaps → identical result sequences, 24 pulses each.
- sof, then 20 pixels, then sof and a full flat frame:
  - 2 results from the aborted frame, for centers (1,1) and (1,2).
  - Then 24 results with out_sof on the first.
- n_rst pulse mid-frame:
  - Outputs go to 0 asynchronously.
  - Subsequent pixels without sof produce no out_valid.
  - The next sof frame is correct.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared types and Sobel arithmetic helpers for the edge-detection pipeline
// (gradient, magnitude and direction stages).
package canny_pkg;

  localparam int PIX_W   = 8;
  localparam int SOBEL_W = 11;

  typedef logic [PIX_W-1:0]          pixel_t;
  typedef logic signed [SOBEL_W-1:0] sobel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // (b0 + 2*b1 + b2) - (a0 + 2*a1 + a2); each weighted sum is at most 1020.
  function automatic sobel_t sobel_diff(
    input pixel_t a0, input pixel_t a1, input pixel_t a2,
    input pixel_t b0, input pixel_t b1, input pixel_t b2
  );
    logic [PIX_W+1:0] sum_a;
    logic [PIX_W+1:0] sum_b;
    sum_a = {2'b00, a0} + {1'b0, a1, 1'b0} + {2'b00, a2};
    sum_b = {2'b00, b0} + {1'b0, b1, 1'b0} + {2'b00, b2};
    return $signed({1'b0, sum_b}) - $signed({1'b0, sum_a});
  endfunction

  // |s| >> 2; |s| <= 1020, so the result always fits a pixel without saturation.
  function automatic pixel_t sobel_mag(input sobel_t s);
    logic [SOBEL_W-1:0] a;
    a = s[SOBEL_W-1] ? SOBEL_W'(-s) : SOBEL_W'(s);
    return a[PIX_W+1:2];
  endfunction

endpackage

// File: rtl/sobel_gradient_line_buffer.sv
// One-line pixel delay: dout_o is the pixel written DEPTH accepted pixels ago.
// Storage is deliberately not reset; stale lines are never observed downstream.
module line_buffer
  import canny_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             shift_en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t             mem [DEPTH];
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (shift_en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem[ptr_q] <= din_i;
    end
  end

  assign dout_o = mem[ptr_q];

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient: two line buffers feed a 3x3 window (stage 1),
// then Sobel sums and |.|>>2 magnitudes are registered to the outputs (stage 2).
module sobel_gradient
  import canny_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             sof,
  output logic             out_valid,
  output logic             out_sof,
  output logic [PIX_W-1:0] gx,
  output logic [PIX_W-1:0] gy,
  output logic             gx_neg,
  output logic             gy_neg
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  // Handshake: a pixel is accepted when pix_valid is high and either sof is
  // set or a frame is ACTIVE; there is no backpressure, outputs are pulses.
  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, cur_col;
  logic [ROW_W-1:0]   row_q, row_d, cur_row;
  logic               accept;
  logic               res_en;
  logic               res_first;

  always_comb begin
    accept    = pix_valid && (sof || (state_q == ACTIVE));
    cur_col   = sof ? '0 : col_q;
    cur_row   = sof ? '0 : row_q;
    res_en    = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    res_first = (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      state_d = ACTIVE;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d = cur_row + 1'b1;
        end
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // lb0 yields the pixel one line above the incoming one, lb1 two lines above.
  pixel_t lb0_dout;
  pixel_t lb1_dout;

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk        (clk),
    .n_rst      (n_rst),
    .shift_en_i (accept),
    .din_i      (pix_in),
    .dout_o     (lb0_dout)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk        (clk),
    .n_rst      (n_rst),
    .shift_en_i (accept),
    .din_i      (lb0_dout),
    .dout_o     (lb1_dout)
  );

  // Window w_q[r][c]: r=0 oldest row, c=0 leftmost column.
  pixel_t [2:0][2:0] w_q;
  logic              s1_valid_q;
  logic              s1_sof_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      w_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
    end else begin
      s1_valid_q <= res_en;
      s1_sof_q   <= res_en && res_first;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          w_q[r][0] <= w_q[r][1];
          w_q[r][1] <= w_q[r][2];
        end
        w_q[0][2] <= lb1_dout;
        w_q[1][2] <= lb0_dout;
        w_q[2][2] <= pix_in;
      end
    end
  end

  sobel_t sx;
  sobel_t sy;

  always_comb begin
    sx = sobel_diff(w_q[0][0], w_q[1][0], w_q[2][0], w_q[0][2], w_q[1][2], w_q[2][2]);
    sy = sobel_diff(w_q[0][0], w_q[0][1], w_q[0][2], w_q[2][0], w_q[2][1], w_q[2][2]);
  end

  logic   out_valid_q;
  logic   out_sof_q;
  pixel_t gx_q;
  pixel_t gy_q;
  logic   gx_neg_q;
  logic   gy_neg_q;

  // Magnitudes and signs only update with a result; they hold between pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      gx_neg_q    <= 1'b0;
      gy_neg_q    <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      out_sof_q   <= s1_sof_q;
      if (s1_valid_q) begin
        gx_q     <= sobel_mag(sx);
        gy_q     <= sobel_mag(sy);
        gx_neg_q <= sx[SOBEL_W-1];
        gy_neg_q <= sy[SOBEL_W-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign gx        = gx_q;
  assign gy        = gy_q;
  assign gx_neg    = gx_neg_q;
  assign gy_neg    = gy_neg_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed bench for sobel_gradient on an 8x6 image: flat, step, gapped,
// aborted-frame and mid-frame reset scenarios with hand-derived results.
module tb_sobel_gradient;

  localparam int W = 8;
  localparam int H = 6;
  localparam int RW = 19;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       sof;
  logic       out_valid;
  logic       out_sof;
  logic [7:0] gx;
  logic [7:0] gy;
  logic       gx_neg;
  logic       gy_neg;

  always #5 clk = ~clk;

  sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .sof       (sof),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .gx        (gx),
    .gy        (gy),
    .gx_neg    (gx_neg),
    .gy_neg    (gy_neg)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int res_cnt   = 0;
  int first_cyc = -1;
  int p22_cyc   = 0;
  bit sb_en     = 1'b0;

  // Entry layout: {sof, gx_neg, gy_neg, gx[7:0], gy[7:0]}
  logic [RW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard
  always @(negedge clk) begin
    if (sb_en && n_rst && out_valid) begin
      logic [RW-1:0] got;
      logic [RW-1:0] exp;
      res_cnt++;
      if (out_sof && first_cyc < 0) first_cyc = cyc;
      got = {out_sof, gx_neg, gy_neg, gx, gy};
      if (exp_q.size() == 0) begin
        check_eq("extra_out", 32'(out_valid), 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check_eq($sformatf("result%0d", res_cnt), 32'(got), 32'(exp));
      end
    end
  end

  // kind: 0 flat 100, 1 vertical step, 2 horizontal step, 3 column ramp
  function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return (c >= 4) ? 8'd200 : 8'd0;
      2:       return (r <= 2) ? 8'd255 : 8'd0;
      default: return 8'(c * 10);
    endcase
  endfunction

  function automatic logic [RW-1:0] exp_of(input int kind, input int cr, input int cc);
    logic       s;
    logic       gxn;
    logic       gyn;
    logic [7:0] ex;
    logic [7:0] ey;
    s = (cr == 1) && (cc == 1);
    gxn = 1'b0; gyn = 1'b0; ex = 8'd0; ey = 8'd0;
    if (kind == 1 && (cc == 3 || cc == 4)) ex = 8'd200;
    if (kind == 2 && (cr == 2 || cr == 3)) begin
      ey  = 8'd255;
      gyn = 1'b1;
    end
    return {s, gxn, gyn, ex, ey};
  endfunction

  task automatic drive_idle();
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic drive_pix(input logic [7:0] p, input logic s, input bit gaps);
    if (gaps) begin
      int n = $urandom_range(0, 2);
      repeat (n) drive_idle();
    end
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = p;
    sof       = s;
  endtask

  task automatic drive_frame(input int kind, input bit gaps, input int npix);
    int n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          drive_pix(pix_of(kind, r, c), (r == 0 && c == 0), gaps);
          if (r == 2 && c == 2) p22_cyc = cyc;
          n++;
        end
      end
    end
  endtask

  task automatic push_frame_exp(input int kind);
    for (int cr = 1; cr <= H - 2; cr++)
      for (int cc = 1; cc <= W - 2; cc++)
        exp_q.push_back(exp_of(kind, cr, cc));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      drive_idle();
      if (exp_q.size() == 0) break;
    end
    repeat (3) drive_idle();
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input int kind, input bit gaps);
    res_cnt   = 0;
    first_cyc = -1;
    push_frame_exp(kind);
    drive_frame(kind, gaps, W * H);
    wait_drain();
    check_eq($sformatf("count_k%0d_g%0d", kind, gaps), 32'(res_cnt), 32'd24);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
    sof       = 1'b0;
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_sof",   32'(out_sof),   32'd0);
    check_eq("rst_gx",        32'(gx),        32'd0);
    check_eq("rst_gy",        32'(gy),        32'd0);
    check_eq("rst_gx_neg",    32'(gx_neg),    32'd0);
    check_eq("rst_gy_neg",    32'(gy_neg),    32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    sb_en = 1'b1;
    repeat (2) drive_idle();

    // Pixels without sof in IDLE are ignored
    res_cnt = 0;
    for (int i = 0; i < 10; i++) drive_pix(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    repeat (4) drive_idle();
    check_eq("idle_ignored", 32'(res_cnt), 32'd0);

    // Flat, steps; then first-result latency on the flat frame
    run_frame(0, 1'b0);
    check_eq("first_latency", 32'(first_cyc), 32'(p22_cyc + 2));
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);

    // Same with random input gaps
    for (int k = 0; k < 3; k++) run_frame(k, 1'b1);

    // Aborted frame: 20 ramp pixels, then sof and a full flat frame
    res_cnt = 0;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'd20, 8'd0});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 8'd20, 8'd0});
    drive_frame(3, 1'b0, 20);
    push_frame_exp(0);
    drive_frame(0, 1'b0, W * H);
    wait_drain();
    check_eq("abort_count", 32'(res_cnt), 32'd26);

    // Reset mid-frame while a gx=200 result is on the outputs
    sb_en = 1'b0;
    drive_frame(1, 1'b0, 22);
    drive_idle();
    drive_idle();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    check_eq("pre_rst_gx",    32'(gx),        32'd200);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_out_sof",   32'(out_sof),   32'd0);
    check_eq("arst_gx",        32'(gx),        32'd0);
    check_eq("arst_gy",        32'(gy),        32'd0);
    check_eq("arst_gx_neg",    32'(gx_neg),    32'd0);
    check_eq("arst_gy_neg",    32'(gy_neg),    32'd0);
    @(negedge clk);
    n_rst   = 1'b1;
    res_cnt = 0;
    sb_en   = 1'b1;
    for (int i = 0; i < 12; i++) drive_pix(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    repeat (4) drive_idle();
    check_eq("post_rst_no_sof", 32'(res_cnt), 32'd0);
    run_frame(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
